// File: rtl/uart_console_pkg.sv
// ---------------------------------------------------------------------------
// uart_console_pkg
//   Shared types and constants for the UART text console.
//   - state_t    : console FSM states (ST_ECHO exists only when the
//                  UART_CONSOLE_ECHO_EN macro is defined)
//   - CH_*       : control characters recognised by the console
//   - PRINT_MIN/PRINT_MAX : inclusive printable range written to the screen
//   - is_printable() : helper deciding whether a byte becomes a cell write
// ---------------------------------------------------------------------------
package uart_console_pkg;

`ifdef UART_CONSOLE_ECHO_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_ECHO  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;
`endif

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= PRINT_MIN) && (ch <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/console_rx_fifo.sv
// ---------------------------------------------------------------------------
// console_rx_fifo
//   Small first-word-fall-through byte FIFO buffering received UART bytes
//   while the console is busy (e.g. during a screen clear).
//   Parameters:
//     DEPTH     entries, power of two, >= 2
//   Ports:
//     clk        system clock
//     reset_n    asynchronous active-low reset
//     push       write strobe, push_data stored when space is available
//     push_data  byte to store
//     pop        remove the head entry (ignored when empty)
//     pop_data   head entry, valid whenever empty is low
//     empty      no entries stored
//     overflow   sticky: a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module console_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       empty,
  output logic       overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic             overflow_reg;
  logic [7:0]       mem_reg [DEPTH];
  logic [DEPTH-1:0] entry_we;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  assign pop_ok = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // is still accepted then.
  assign push_ok = push && (!full || pop_ok);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign entry_we[gi] = push_ok && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        mem_reg[i] <= push_data;
      end
    end
  end

  // Head is read combinationally so the console can decode it in the pop cycle.
  assign pop_data = mem_reg[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign overflow = overflow_reg;

endmodule

// File: rtl/uart_text_console.sv
// ---------------------------------------------------------------------------
// uart_text_console
//   Turns received UART bytes into writes to a VGA text-cell RAM. Keeps a
//   cursor, interprets CR, LF, BS and FF (clear screen), buffers bytes in a
//   small FIFO and optionally echoes every processed byte back to the UART.
//
//   Optional feature macro: UART_CONSOLE_ECHO_EN
//     defined   : every decoded byte is echoed via tx_start/tx_data once its
//                 action is done, waiting while tx_busy is high.
//     undefined : no echo; tx_start/tx_data are 0 and tx_busy is ignored.
//
//   Parameters: COLS, ROWS, FIFO_DEPTH (power of 2, >= 2), COLOR_W.
//   Ports:
//     clk        system clock
//     reset_n    asynchronous active-low reset
//     rx_data    received byte, rx_valid one-cycle strobe
//     color_sel  colour stored with every cell written
//     wr_en      text RAM write strobe
//     wr_addr    cell address row*COLS+col
//     wr_data    {colour, char}
//     cur_row    cursor row, cur_col cursor column
//     overflow   sticky: a byte was dropped on a full FIFO
//     tx_data    echo byte, tx_start one-cycle echo request
//     tx_busy    transmitter busy
// ---------------------------------------------------------------------------
module uart_text_console
  import uart_console_pkg::*;
#(
  parameter  int COLS       = 80,
  parameter  int ROWS       = 30,
  parameter  int FIFO_DEPTH = 4,
  parameter  int COLOR_W    = 2,
  localparam int ADDR_W     = $clog2(COLS * ROWS),
  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic [COLOR_W-1:0]   color_sel,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [COLOR_W+7:0]   wr_data,
  output logic [ROW_W-1:0]     cur_row,
  output logic [COL_W-1:0]     cur_col,
  output logic                 overflow,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy
);

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(COLS * ROWS - 1);

  // State entered once a byte's own action has finished.
`ifdef UART_CONSOLE_ECHO_EN
  localparam state_t ST_DONE = ST_ECHO;
`else
  localparam state_t ST_DONE = ST_IDLE;
`endif

  state_t               state_reg;
  logic                 wr_en_reg;
  logic [ADDR_W-1:0]    wr_addr_reg;
  logic [COLOR_W+7:0]   wr_data_reg;
  logic [ROW_W-1:0]     row_reg;
  logic [COL_W-1:0]     col_reg;

  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [7:0]           fifo_data;
  logic [ADDR_W-1:0]    cell_addr;
  logic [ROW_W-1:0]     row_wrap_next;

  console_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

  // The head byte is consumed in the same cycle it is decoded.
  assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;

  assign cell_addr     = ADDR_W'(row_reg) * ADDR_W'(COLS) + ADDR_W'(col_reg);
  assign row_wrap_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;

`ifdef UART_CONSOLE_ECHO_EN
  logic [7:0] byte_reg;
  logic [7:0] tx_data_reg;
  logic       tx_start_reg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
`ifdef UART_CONSOLE_ECHO_EN
      byte_reg     <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
`endif
    end else begin
      wr_en_reg <= 1'b0;
`ifdef UART_CONSOLE_ECHO_EN
      tx_start_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
`ifdef UART_CONSOLE_ECHO_EN
            byte_reg <= fifo_data;
`endif
            state_reg <= ST_DONE;
            if (is_printable(fifo_data)) begin
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= cell_addr;
              wr_data_reg <= {color_sel, fifo_data};
              if (col_reg == COL_LAST) begin
                col_reg <= '0;
                row_reg <= row_wrap_next;
              end else begin
                col_reg <= col_reg + 1'b1;
              end
              state_reg <= ST_WRITE;
            end else begin
              case (fifo_data)
                CH_CR: col_reg <= '0;
                CH_LF: row_reg <= row_wrap_next;
                CH_BS: begin
                  // Backspace at column 0 is a no-op; otherwise blank the
                  // cell left of the cursor, which stays on the same row.
                  if (col_reg != '0) begin
                    col_reg     <= col_reg - 1'b1;
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= cell_addr - ADDR_W'(1);
                    wr_data_reg <= {color_sel, CH_SPACE};
                    state_reg   <= ST_WRITE;
                  end
                end
                CH_FF: begin
                  // First sweep write is issued here; wr_addr_reg then
                  // doubles as the sweep counter.
                  wr_en_reg   <= 1'b1;
                  wr_addr_reg <= '0;
                  wr_data_reg <= {color_sel, CH_SPACE};
                  state_reg   <= ST_CLEAR;
                end
                default: ;
              endcase
            end
          end
        end

        // Spacer cycle while the write is on the bus; keeps writes from
        // successive bytes at least one cycle apart.
        ST_WRITE: state_reg <= ST_DONE;

        ST_CLEAR: begin
          if (wr_addr_reg == ADDR_LAST) begin
            row_reg   <= '0;
            col_reg   <= '0;
            state_reg <= ST_DONE;
          end else begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= wr_addr_reg + 1'b1;
          end
        end

`ifdef UART_CONSOLE_ECHO_EN
        ST_ECHO: begin
          if (!tx_busy) begin
            tx_start_reg <= 1'b1;
            tx_data_reg  <= byte_reg;
            state_reg    <= ST_IDLE;
          end
        end
`endif

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign cur_row = row_reg;
  assign cur_col = col_reg;

`ifdef UART_CONSOLE_ECHO_EN
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
`else
  logic unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign tx_start = 1'b0;
  assign tx_data  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_text_console.sv
module tb_uart_text_console;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int NCELL = COLS * ROWS;
`ifdef UART_CONSOLE_ECHO_EN
  localparam int SVC = 3;
`else
  localparam int SVC = 2;
`endif

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_valid  = 1'b0;
  logic [1:0]  color_sel = 2'b00;
  logic        tx_busy   = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [9:0]  wr_data;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        overflow;
  logic [7:0]  tx_data;
  logic        tx_start;

  uart_text_console #(
    .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(4), .COLOR_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .color_sel(color_sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cur_row(cur_row), .cur_col(cur_col), .overflow(overflow),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observed and expected cell writes as {addr, colour, char}.
  logic [21:0] obs_q[$];
  logic [21:0] exp_q[$];
  int          obs_cyc_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_tx_q[$];
  int          m_row;
  int          m_col;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_q.push_back({wr_addr, wr_data});
      obs_cyc_q.push_back(cyc);
    end
    if (tx_start === 1'b1) tx_q.push_back(tx_data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Screen model: cursor plus the list of cell writes a byte must cause.
  task automatic model_byte(input logic [7:0] b, input logic [1:0] c);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({12'(m_row * COLS + m_col), c, b});
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_row = (m_row + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_q.push_back({12'(m_row * COLS + m_col), c, 8'h20});
      end
    end else if (b == 8'h0C) begin
      for (int a = 0; a < NCELL; a++) exp_q.push_back({12'(a), c, 8'h20});
      m_row = 0;
      m_col = 0;
    end
`ifdef UART_CONSOLE_ECHO_EN
    exp_tx_q.push_back(b);
`endif
  endtask

  // Drives one byte for one cycle; 'kept' says whether the FIFO will accept it.
  task automatic send(input logic [7:0] b, input logic [1:0] c, input bit kept);
    rx_data   = b;
    rx_valid  = 1'b1;
    color_sel = c;
    if (kept) model_byte(b, c);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic tb_reset();
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs_q.delete(); obs_cyc_q.delete(); tx_q.delete();
    exp_q.delete(); exp_tx_q.delete();
    m_row = 0;
    m_col = 0;
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    tb_reset();
    n_assert++;
    if ({wr_en, wr_addr, wr_data, cur_row, cur_col, overflow, tx_start, tx_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: outputs=%h required 0", {wr_en, wr_addr, wr_data, cur_row, cur_col, overflow, tx_start, tx_data});
    end
    send(8'h41, 2'b01, 1'b1);
    tick(SVC + 2);
    send(8'h42, 2'b01, 1'b1);
    tick(SVC + 2);
    send(8'h0C, 2'b10, 1'b1);
    for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), 2'b10, 1'b0);
    tick(40);
    n_assert++;
    if (wr_en !== 1'b1 || overflow !== 1'b1 || cur_col !== 7'd2) begin
      n_fail++;
      $display("FAIL reset_precond: wr_en=%b overflow=%b col=%0d required 1 1 2", wr_en, overflow, cur_col);
    end
    #2 reset_n = 1'b0;
    #1;
    n_assert++;
    if (wr_en !== 1'b0 || tx_start !== 1'b0 || overflow !== 1'b0 || cur_row !== 5'd0 || cur_col !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_async: wr_en=%b tx_start=%b overflow=%b cursor=(%0d,%0d) required 0 0 0 (0,0)",
               wr_en, tx_start, overflow, cur_row, cur_col);
    end
    obs_q.delete(); obs_cyc_q.delete(); tx_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick(30);
    n_assert++;
    if (obs_q.size() != 0 || tx_q.size() != 0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abandon: writes=%0d echoes=%0d overflow=%b required 0 0 0", obs_q.size(), tx_q.size(), overflow);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    int k;
    tb_reset();
    k = cyc;
    send(8'h41, 2'b01, 1'b1);
    tick(8);
    n_assert++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: writes=%0d required 1", obs_q.size());
    end else begin
      n_assert++;
      if (obs_cyc_q[0] != k + 2) begin
        n_fail++;
        $display("FAIL single_latency: write cycle=%0d required %0d", obs_cyc_q[0], k + 2);
      end
      n_assert++;
      if (obs_q[0] !== {12'd0, 2'b01, 8'h41}) begin
        n_fail++;
        $display("FAIL single_data: got %h required %h", obs_q[0], {12'd0, 2'b01, 8'h41});
      end
    end
    n_assert++;
    if (cur_row !== 5'd0 || cur_col !== 7'd1) begin
      n_fail++;
      $display("FAIL single_cursor: (%0d,%0d) required (0,1)", cur_row, cur_col);
    end
    $display("test_single_write: 1 write at cycle offset 2");
  endtask

  task automatic test_row_wrap();
    int bad;
    tb_reset();
    for (int i = 0; i < 81; i++) begin
      send(8'h41, 2'b11, 1'b1);
      tick(SVC);
    end
    tick(6);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    n_assert++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL row_wrap_writes: %0d mismatches, got %0d writes required %0d", bad, obs_q.size(), exp_q.size());
    end
    n_assert++;
    if (obs_q.size() == 81 && obs_q[80][21:10] !== 12'd80) begin
      n_fail++;
      $display("FAIL row_wrap_addr: 81st addr=%0d required 80", obs_q[80][21:10]);
    end
    n_assert++;
    if (cur_row !== 5'd1 || cur_col !== 7'd1) begin
      n_fail++;
      $display("FAIL row_wrap_cursor: (%0d,%0d) required (1,1)", cur_row, cur_col);
    end
    $display("test_row_wrap: %0d writes checked", exp_q.size());
  endtask

  task automatic test_corner_wrap();
    int bad;
    tb_reset();
    for (int i = 0; i < ROWS - 1; i++) begin
      send(8'h0A, 2'b00, 1'b1);
      tick(SVC);
    end
    for (int i = 0; i < COLS - 1; i++) begin
      send(8'h61, 2'b10, 1'b1);
      tick(SVC);
    end
    send(8'h42, 2'b10, 1'b1);
    tick(SVC + 6);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    n_assert++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL corner_writes: %0d mismatches, got %0d writes required %0d", bad, obs_q.size(), exp_q.size());
    end
    n_assert++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== {12'd2399, 2'b10, 8'h42}) begin
      n_fail++;
      $display("FAIL corner_last: got %h required %h", (obs_q.size() == 0) ? 22'h0 : obs_q[obs_q.size()-1], {12'd2399, 2'b10, 8'h42});
    end
    n_assert++;
    if (cur_row !== 5'd0 || cur_col !== 7'd0) begin
      n_fail++;
      $display("FAIL corner_cursor: (%0d,%0d) required (0,0)", cur_row, cur_col);
    end
    $display("test_corner_wrap: %0d writes checked", exp_q.size());
  endtask

  task automatic test_backspace();
    tb_reset();
    send(8'h0A, 2'b01, 1'b1); tick(SVC);
    send(8'h58, 2'b01, 1'b1); tick(SVC);
    send(8'h08, 2'b01, 1'b1); tick(SVC + 4);
    n_assert++;
    if (obs_q.size() != 2 || obs_q[0] !== {12'd80, 2'b01, 8'h58} || obs_q[1] !== {12'd80, 2'b01, 8'h20}) begin
      n_fail++;
      $display("FAIL backspace_writes: count=%0d first=%h second=%h required 2 %h %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 22'h0, (obs_q.size() > 1) ? obs_q[1] : 22'h0,
               {12'd80, 2'b01, 8'h58}, {12'd80, 2'b01, 8'h20});
    end
    n_assert++;
    if (cur_row !== 5'd1 || cur_col !== 7'd0) begin
      n_fail++;
      $display("FAIL backspace_cursor: (%0d,%0d) required (1,0)", cur_row, cur_col);
    end
    send(8'h08, 2'b01, 1'b1); tick(SVC + 4);
    n_assert++;
    if (obs_q.size() != 2 || cur_row !== 5'd1 || cur_col !== 7'd0) begin
      n_fail++;
      $display("FAIL backspace_col0: writes=%0d cursor=(%0d,%0d) required 2 (1,0)", obs_q.size(), cur_row, cur_col);
    end
    $display("test_backspace: 2 writes checked");
  endtask

  task automatic test_clear();
    int bad;
    tb_reset();
    send(8'h0C, 2'b10, 1'b1);
    send(8'h5A, 2'b10, 1'b1);
    send(8'h51, 2'b10, 1'b1);
    tick(NCELL + 40);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    n_assert++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL clear_writes: %0d mismatches, got %0d writes required %0d", bad, obs_q.size(), exp_q.size());
    end
    n_assert++;
    if (obs_cyc_q.size() >= NCELL && obs_cyc_q[NCELL-1] - obs_cyc_q[0] != NCELL - 1) begin
      n_fail++;
      $display("FAIL clear_rate: sweep took %0d cycles required %0d", obs_cyc_q[NCELL-1] - obs_cyc_q[0] + 1, NCELL);
    end
    n_assert++;
    if (overflow !== 1'b0 || cur_row !== 5'd0 || cur_col !== 7'd2) begin
      n_fail++;
      $display("FAIL clear_state: overflow=%b cursor=(%0d,%0d) required 0 (0,2)", overflow, cur_row, cur_col);
    end
    $display("test_clear: %0d writes checked", exp_q.size());
  endtask

  task automatic test_overflow();
    int bad;
    int dropped_seen;
    tb_reset();
    send(8'h0C, 2'b01, 1'b1);
    for (int i = 0; i < 6; i++) send(8'h31 + 8'(i), 2'b01, i < 4);
    tick(NCELL + 60);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    n_assert++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL overflow_writes: %0d mismatches, got %0d writes required %0d", bad, obs_q.size(), exp_q.size());
    end
    dropped_seen = 0;
    foreach (obs_q[i]) if (obs_q[i][7:0] == 8'h35 || obs_q[i][7:0] == 8'h36) dropped_seen++;
    n_assert++;
    if (dropped_seen != 0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: dropped bytes written=%0d overflow=%b required 0 1", dropped_seen, overflow);
    end
    $display("test_overflow: %0d writes checked", exp_q.size());
  endtask

  task automatic test_back_to_back();
    int bad;
    int d;
    tb_reset();
    for (int i = 0; i < 4; i++) send(8'h61 + 8'(i), 2'b11, 1'b1);
    tick(4 * SVC + 8);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    n_assert++;
    if (bad != 0 || obs_q.size() != exp_q.size() || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_writes: %0d mismatches, got %0d writes required %0d, overflow=%b", bad, obs_q.size(), exp_q.size(), overflow);
    end
    for (int i = 1; i < obs_cyc_q.size(); i++) begin
      d = obs_cyc_q[i] - obs_cyc_q[i-1];
      n_assert++;
      if (d < 2 || (SVC == 2 && d != 2)) begin
        n_fail++;
        $display("FAIL b2b_spacing: write %0d gap=%0d cycles required %0d", i, d, SVC == 2 ? 2 : 3);
      end
    end
    $display("test_back_to_back: %0d writes checked", exp_q.size());
  endtask

  task automatic test_random();
    int bad;
    int r;
    logic [7:0] b;
    tb_reset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      b = 8'($urandom_range(32, 126));
      else if (r == 6) b = 8'h0D;
      else if (r == 7) b = 8'h0A;
      else if (r == 8) b = 8'h08;
      else             b = 8'h80 | 8'($urandom_range(0, 127));
      send(b, 2'($urandom_range(0, 3)), 1'b1);
      tick(SVC + $urandom_range(0, 2));
    end
    tick(10);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    n_assert++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_writes: %0d mismatches, got %0d writes required %0d", bad, obs_q.size(), exp_q.size());
    end
    n_assert++;
    if (cur_row !== 5'(m_row) || cur_col !== 7'(m_col) || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL random_cursor: (%0d,%0d) overflow=%b required (%0d,%0d) 0", cur_row, cur_col, overflow, m_row, m_col);
    end
    bad = 0;
    foreach (exp_tx_q[i]) if (i >= tx_q.size() || tx_q[i] !== exp_tx_q[i]) bad++;
    n_assert++;
    if (bad != 0 || tx_q.size() != exp_tx_q.size()) begin
      n_fail++;
      $display("FAIL random_echo: %0d mismatches, got %0d echoes required %0d", bad, tx_q.size(), exp_tx_q.size());
    end
    $display("test_random: %0d writes, %0d echoes checked", exp_q.size(), exp_tx_q.size());
  endtask

`ifdef UART_CONSOLE_ECHO_EN
  task automatic test_echo();
    tb_reset();
    tx_busy = 1'b1;
    send(8'h41, 2'b01, 1'b1);
    tick(10);
    n_assert++;
    if (tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL echo_busy: %0d tx_start pulses while busy, required 0", tx_q.size());
    end
    tx_busy = 1'b0;
    for (int i = 0; i < 20 && tx_q.size() == 0; i++) tick(1);
    tick(10);
    n_assert++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h41) begin
      n_fail++;
      $display("FAIL echo_pulse: %0d pulses, first byte %h, required 1 pulse of 41", tx_q.size(),
               (tx_q.size() > 0) ? tx_q[0] : 8'h00);
    end
    $display("test_echo: %0d echo pulses seen", tx_q.size());
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_row_wrap();
    test_corner_wrap();
    test_backspace();
    test_clear();
    test_overflow();
    test_back_to_back();
    test_random();
`ifdef UART_CONSOLE_ECHO_EN
    test_echo();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
